cpu_muldiv_ctrl: RTL and testbench

Multi-cycle MULT/MULTU/DIV/DIVU sequencer in the EX stage of the 5-stage CPU pipeline. It accepts one HI/LO-writing op from EX and runs an iterative divider or a registered multiplier. While busy it raises a stall request to the pipeline stall controller. It then presents the HI/LO write bundle (w_hi/hi_data/w_lo/lo_data), which EX forwards down the pipeline to the Writeback HI/LO register port.

---
 rtl/cpu_muldiv_pkg.sv | 28 ++
 rtl/cpu_div_iter.sv | 67 ++++++
 rtl/cpu_muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cpu_muldiv_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_muldiv_pkg.sv
// Shared encodings and constants for the EX-stage HI/LO mul/div sequencer.
package cpu_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int          DIV_ITER = 32;
  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/cpu_div_iter.sv
// Radix-2 restoring divider, one quotient bit per cycle on unsigned magnitudes.
module cpu_div_iter
  import cpu_muldiv_pkg::*;
(
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam logic [4:0] LAST = 5'(DIV_ITER - 1);

  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [32:0] trial;
  logic        ge;
  logic [31:0] quo_n, rem_n;

  // quot_o/rem_o are the post-step values so the final bit is usable on the same edge
  always_comb begin
    trial = {rem_q, quo_q[31]};
    ge    = (trial >= {1'b0, dvs_q});
    rem_n = ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
    quo_n = {quo_q[30:0], ge};
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign quot_o = quo_n;
  assign rem_o  = rem_n;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (kill_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (busy_q) begin
      quo_q <= quo_n;
      rem_q <= rem_n;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/cpu_muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer: stalls the pipe while busy and
// presents a registered HI/LO write bundle until EX advances.
module cpu_muldiv_ctrl
  import cpu_muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic [4:0]  stall_i,
  output logic        stall_req_o,
  output logic        done_o,
  output logic        w_hi_o,
  output logic        w_lo_o,
  output logic [31:0] hi_data_o,
  output logic [31:0] lo_data_o
);

  state_e      state_q, state_d;
  logic        ack_q, accept, load;
  logic        sgn_in, sgn_q, sa_q, sb_q;
  logic [1:0]  mcnt_q;
  logic [63:0] pipe_q [MUL_STAGES];
  logic [31:0] mag_a, mag_b;
  logic        div_start, div_busy, div_last;
  logic [31:0] div_q, div_r;
  logic [63:0] prod_fix;
  logic [31:0] hi_d, lo_d, hi_q, lo_q;
  logic        done_q;
  logic        unused_stall;

  assign unused_stall = ^{stall_i[4:3], stall_i[1:0]};

  assign sgn_in = ~op_i[0];
  assign mag_a  = mag32(src_a_i, sgn_in);
  assign mag_b  = mag32(src_b_i, sgn_in);

  // ack_q masks the op still sitting on start in the cycle after it was consumed
  assign accept    = start_i && !flush_i && !ack_q;
  assign div_start = (state_q == ST_IDLE) && accept && op_i[1] && (src_b_i != '0);
  assign load      = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_q == ST_DONE) && (state_d == ST_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!op_i[1])            state_d = ST_MUL;
          else if (src_b_i == '0)  state_d = ST_DONE;
          else                     state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        if (flush_i)                           state_d = ST_IDLE;
        else if (mcnt_q == 2'(MUL_STAGES - 1)) state_d = ST_DONE;
      end
      ST_DIV: begin
        if (flush_i)        state_d = ST_IDLE;
        else if (div_last)  state_d = ST_DONE;
        else if (!div_busy) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (flush_i || !stall_i[2]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_req_o = 1'b0;
    unique case (state_q)
      ST_IDLE: stall_req_o = accept;
      ST_MUL:  stall_req_o = 1'b1;
      ST_DIV:  stall_req_o = 1'b1;
      default: stall_req_o = 1'b0;
    endcase
  end

  cpu_div_iter u_div (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (div_start),
    .kill_i     (flush_i),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .busy_o     (div_busy),
    .done_o     (div_last),
    .quot_o     (div_q),
    .rem_o      (div_r)
  );

  always_comb begin
    prod_fix = pipe_q[MUL_STAGES-1];
    if (sgn_q && (sa_q ^ sb_q)) prod_fix = -pipe_q[MUL_STAGES-1];
    hi_d = src_a_i;
    lo_d = DIV0_LO;
    unique case (state_q)
      ST_MUL: {hi_d, lo_d} = prod_fix;
      ST_DIV: begin
        lo_d = (sgn_q && (sa_q ^ sb_q)) ? -div_q : div_q;
        hi_d = (sgn_q && sa_q) ? -div_r : div_r;
      end
      default: ;
    endcase
  end

  // pipe_q free-runs; the slot that reaches the end of MUL holds the accept-edge product
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sgn_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      mcnt_q <= '0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {32'b0, mag_a} * {32'b0, mag_b};
      for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      if (state_q == ST_IDLE) begin
        mcnt_q <= '0;
        if (accept) begin
          sgn_q <= sgn_in;
          sa_q  <= src_a_i[31];
          sb_q  <= src_b_i[31];
        end
      end else if (state_q == ST_MUL) begin
        mcnt_q <= mcnt_q + 2'd1;
      end
      done_q <= (state_d == ST_DONE);
      if (load) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign done_o    = done_q;
  assign w_hi_o    = done_q;
  assign w_lo_o    = done_q;
  assign hi_data_o = hi_q;
  assign lo_data_o = lo_q;

endmodule

// File: tb/tb_cpu_muldiv_ctrl.sv
// Scoreboard bench for cpu_muldiv_ctrl: directed ops, stall hold, flush, reset.
module tb_cpu_muldiv_ctrl;
  import cpu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  stall = '0;
  logic        stall_req, done, w_hi, w_lo;
  logic [31:0] hi, lo;

  cpu_muldiv_ctrl #(.MUL_STAGES(1)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .op_i        (op),
    .src_a_i     (a),
    .src_b_i     (b),
    .flush_i     (flush),
    .stall_i     (stall),
    .stall_req_o (stall_req),
    .done_o      (done),
    .w_hi_o      (w_hi),
    .w_lo_o      (w_lo),
    .hi_data_o   (hi),
    .lo_data_o   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev = 1'b0;
    end else begin
      if (done) begin
        check("w_hi_w_lo", {62'b0, w_hi, w_lo}, 64'd3);
        if (!prev) begin
          if (q.size() == 0) begin
            check("unexpected_done", {63'b0, done}, 64'd0);
          end else begin
            cur = q.pop_front();
            check("hi", {32'b0, hi}, {32'b0, cur.hi});
            check("lo", {32'b0, lo}, {32'b0, cur.lo});
            check("done_cycle", 64'(cyc), 64'(cur.cyc));
          end
        end else begin
          check("hold_hi", {32'b0, hi}, {32'b0, cur.hi});
          check("hold_lo", {32'b0, lo}, {32'b0, cur.lo});
        end
      end
      prev = done;
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] sa,
                        input logic [31:0] sb, input logic [31:0] eh,
                        input logic [31:0] el, input int lat,
                        input int nstall);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = sa; b = sb;
    e.hi = eh; e.lo = el; e.cyc = cyc + lat;
    q.push_back(e);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check("stall_req_busy", {63'b0, stall_req}, 64'd1);
      @(posedge clk); #1;
    end
    if (nstall > 0) stall[2] = 1'b1;
    for (int k = 0; k < nstall; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    stall[2] = 1'b0;
    @(negedge clk);
    check("stall_req_done", {63'b0, stall_req}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("no_reaccept", {63'b0, stall_req}, 64'd0);
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_stall_req", {63'b0, stall_req}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    rst = 1'b0;

    run_op(OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 0);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 2, 0);
    run_op(OP_MULT,  32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, 0);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0);
    run_op(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 0);
    run_op(OP_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 0);
    run_op(OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0);
    run_op(OP_DIV,   32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 1, 0);
    run_op(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33, 3);

    // flush a DIV at cycle 10; no result may appear
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_stall_req", {63'b0, stall_req}, 64'd0);
    run_op(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 2, 0);

    // asynchronous reset mid-DIV at cycle 15
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
    repeat (15) @(posedge clk);
    #2;
    check("pre_rst_stall_req", {63'b0, stall_req}, 64'd1);
    rst = 1'b1; start = 1'b0;
    #1;
    check("async_rst_stall_req", {63'b0, stall_req}, 64'd0);
    check("async_rst_done", {63'b0, done}, 64'd0);
    check("async_rst_hi", {32'b0, hi}, 64'd0);
    check("async_rst_lo", {32'b0, lo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, 0);

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
